// File: rtl/autoplay_driver.sv
// Right-hand-rule maze solver that drives synthetic button presses into the player logic.
// Optional macro AUTOPLAY_MOVE_CHECK_EN: accept a move only when player_pos reaches the latched target.
module autoplay_driver #(
  parameter int PRESS_CYCLES          = 524288,
  parameter int RELEASE_CYCLES        = 524288,
  parameter int MAX_STEPS             = 1023,
  parameter int maze_width            = 8,
  parameter int maze_height           = 8,
  parameter int maze_flat             = maze_width * maze_height - 1,
  parameter int maze_player_dim_split = $clog2(maze_height),
  parameter int maze_player_dim       = $clog2(maze_width) + $clog2(maze_height) - 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [maze_flat:0]       maze,
  input  logic [maze_player_dim:0] player_pos,
  input  logic                     win,
  output logic                     btnU,
  output logic                     btnD,
  output logic                     btnL,
  output logic                     btnR,
  output logic                     busy,
  output logic                     done,
  output logic                     fail,
  output logic [9:0]               step_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_EVAL    = 3'd1;
  localparam logic [2:0] S_PRESS   = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_CHECK   = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [2:0] S_FAIL    = 3'd6;

  localparam logic [1:0] DIR_L = 2'd0;
  localparam logic [1:0] DIR_D = 2'd1;
  localparam logic [1:0] DIR_R = 2'd2;
  localparam logic [1:0] DIR_U = 2'd3;

  localparam int XW      = maze_player_dim - maze_player_dim_split + 1;
  localparam int YW      = maze_player_dim_split;
  localparam int IW      = $clog2(maze_flat + 1);
  localparam int CNT_MAX = (PRESS_CYCLES > RELEASE_CYCLES) ? PRESS_CYCLES : RELEASE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] PRESS_LAST   = CW'(PRESS_CYCLES - 1);
  localparam logic [CW-1:0] RELEASE_LAST = CW'(RELEASE_CYCLES - 1);
  localparam logic [XW:0]   X_LIM        = maze_width[XW:0];
  localparam logic [YW:0]   Y_LIM        = maze_height[YW:0];
  localparam logic [XW:0]   X_ONE        = {{XW{1'b0}}, 1'b1};
  localparam logic [YW:0]   Y_ONE        = {{YW{1'b0}}, 1'b1};
  localparam logic [IW-1:0] ROW_STRIDE   = maze_width[IW-1:0];
  localparam logic [IW-1:0] MAX_IDX      = maze_flat[IW-1:0];
  localparam logic [9:0]    STEP_LIMIT   = MAX_STEPS[9:0];

  logic [2:0]    r_state;
  logic [1:0]    r_heading;
  logic [1:0]    r_dir;
  logic [1:0]    r_cand;
  logic [CW-1:0] r_cnt;
  logic [9:0]    r_step_count;
  logic [3:0]    r_btn;
  logic          r_busy;
  logic          r_done;
  logic          r_fail;

  logic [2:0]    w_next_state;
  logic [1:0]    w_cand_dir;
  logic [1:0]    w_press_dir;
  logic [XW:0]   w_px;
  logic [YW:0]   w_py;
  logic [XW:0]   w_nx;
  logic [YW:0]   w_ny;
  logic          w_inb;
  logic [IW-1:0] w_idx;
  logic          w_open;
  logic          w_accept;
  logic [9:0]    w_step_inc;
  logic [3:0]    w_btn_next;

  assign w_px       = {1'b0, player_pos[maze_player_dim:maze_player_dim_split]};
  assign w_py       = {1'b0, player_pos[maze_player_dim_split-1:0]};
  // Candidate k of the right-hand sweep is heading-1+k, wrapping in 2 bits.
  assign w_cand_dir = r_heading + 2'd3 + r_cand;
  assign w_step_inc = r_step_count + 10'd1;

  always_comb begin
    w_nx = w_px;
    w_ny = w_py;
    case (w_cand_dir)
      DIR_L:   w_nx = w_px - X_ONE;
      DIR_D:   w_ny = w_py + Y_ONE;
      DIR_R:   w_nx = w_px + X_ONE;
      DIR_U:   w_ny = w_py - Y_ONE;
      default: w_nx = w_px;
    endcase
  end

  // Underflow past 0 wraps to the top of the extra-bit range and fails the bound test.
  assign w_inb  = (w_nx < X_LIM) && (w_ny < Y_LIM);
  assign w_idx  = IW'(w_ny[YW-1:0]) * ROW_STRIDE + IW'(w_nx[XW-1:0]);
  assign w_open = w_inb && (w_idx <= MAX_IDX) && !maze[w_idx];

`ifdef AUTOPLAY_MOVE_CHECK_EN
  logic [XW-1:0] r_tx;
  logic [YW-1:0] r_ty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx <= '0;
      r_ty <= '0;
    end else if (!abort && r_state == S_EVAL && !win && w_open) begin
      r_tx <= w_nx[XW-1:0];
      r_ty <= w_ny[YW-1:0];
    end
  end

  assign w_accept = (player_pos == {r_tx, r_ty});
`else
  assign w_accept = 1'b1;
`endif

  always_comb begin
    w_next_state = r_state;
    if (abort) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_FAIL: if (start) w_next_state = S_EVAL;
        S_EVAL: begin
          if (win)                 w_next_state = S_DONE;
          else if (w_open)         w_next_state = S_PRESS;
          else if (r_cand == 2'd3) w_next_state = S_FAIL;
        end
        S_PRESS:   if (r_cnt == PRESS_LAST)   w_next_state = S_RELEASE;
        S_RELEASE: if (r_cnt == RELEASE_LAST) w_next_state = S_CHECK;
        S_CHECK: begin
          if (!w_accept)                     w_next_state = S_FAIL;
          else if (win)                      w_next_state = S_DONE;
          else if (w_step_inc == STEP_LIMIT) w_next_state = S_FAIL;
          else                               w_next_state = S_EVAL;
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // Buttons are computed from the next state so each is a clean register output.
  assign w_press_dir = (r_state == S_EVAL) ? w_cand_dir : r_dir;
  assign w_btn_next  = (w_next_state == S_PRESS) ? (4'b0001 << w_press_dir) : 4'b0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_heading    <= DIR_R;
      r_dir        <= DIR_R;
      r_cand       <= 2'd0;
      r_cnt        <= '0;
      r_step_count <= 10'd0;
      r_btn        <= 4'b0000;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_fail       <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_btn   <= w_btn_next;
      r_busy  <= (w_next_state != S_IDLE) && (w_next_state != S_DONE) && (w_next_state != S_FAIL);
      r_done  <= (w_next_state == S_DONE);
      r_fail  <= (w_next_state == S_FAIL);
      if (abort) begin
        r_cnt  <= '0;
        r_cand <= 2'd0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE, S_FAIL: begin
            if (start) begin
              r_heading    <= DIR_R;
              r_step_count <= 10'd0;
              r_cand       <= 2'd0;
              r_cnt        <= '0;
            end
          end
          S_EVAL: begin
            if (!win) begin
              if (w_open) begin
                r_dir <= w_cand_dir;
                r_cnt <= '0;
              end else begin
                r_cand <= r_cand + 2'd1;
              end
            end
          end
          S_PRESS:   r_cnt <= (r_cnt == PRESS_LAST)   ? '0 : r_cnt + 1'b1;
          S_RELEASE: r_cnt <= (r_cnt == RELEASE_LAST) ? '0 : r_cnt + 1'b1;
          S_CHECK: begin
            r_cand <= 2'd0;
            if (w_accept) begin
              r_heading    <= r_dir;
              r_step_count <= w_step_inc;
            end
          end
          default: r_cnt <= '0;
        endcase
      end
    end
  end

  assign btnL       = r_btn[0];
  assign btnD       = r_btn[1];
  assign btnR       = r_btn[2];
  assign btnU       = r_btn[3];
  assign busy       = r_busy;
  assign done       = r_done;
  assign fail       = r_fail;
  assign step_count = r_step_count;

endmodule

// File: tb/tb_autoplay_driver.sv
// Bench for autoplay_driver: player model, right-hand-rule reference walk and press scoreboard.
module tb_autoplay_driver;
  localparam int PC = 4;
  localparam int RC = 4;
  localparam int MS = 30;

  logic        clk = 1'b0;
  logic        rst, start, abort, win;
  logic [63:0] maze;
  logic [5:0]  player_pos;
  logic        btnU, btnD, btnL, btnR, busy, done, fail;
  logic [9:0]  step_count;
  logic [3:0]  btn;

  autoplay_driver #(.PRESS_CYCLES(PC), .RELEASE_CYCLES(RC), .MAX_STEPS(MS)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .maze(maze),
    .player_pos(player_pos), .win(win), .btnU(btnU), .btnD(btnD), .btnL(btnL),
    .btnR(btnR), .busy(busy), .done(done), .fail(fail), .step_count(step_count)
  );

  always #5 clk = ~clk;

  // bit index = direction code: 0=L 1=D 2=R 3=U
  assign btn = {btnU, btnR, btnD, btnL};

  typedef struct { logic [3:0] vec; int len; } press_t;
  press_t exp_q[$];
  int n_pass = 0;
  int n_total = 0;
  int exp_steps;
  bit exp_done, exp_fail;

  task automatic chk(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic note_fail(input string name, input int act);
    n_total++;
    $display("FAIL %s: observed %0d where none was allowed", name, act);
  endtask

  function automatic int dxf(input int d);
    return (d == 0) ? -1 : (d == 2) ? 1 : 0;
  endfunction

  function automatic int dyf(input int d);
    return (d == 1) ? 1 : (d == 3) ? -1 : 0;
  endfunction

  function automatic bit cell_open(input logic [63:0] m, input int x, input int y);
    if (x < 0 || x >= 8 || y < 0 || y >= 8) return 1'b0;
    return !m[6'(y * 8 + x)];
  endfunction

  // Player model: moves one cell on the first cycle of each press unless frozen.
  logic [2:0] px = 3'd0, py = 3'd0, gx = 3'd7, gy = 3'd7;
  logic [2:0] load_x = 3'd0, load_y = 3'd0;
  logic       load = 1'b0, freeze = 1'b0, goal_en = 1'b0;
  logic [3:0] prev_btn = 4'd0;

  assign player_pos = {px, py};
  assign win = goal_en && (px == gx) && (py == gy);

  always @(posedge clk) begin
    int nx, ny;
    prev_btn <= btn;
    if (load) begin
      px <= load_x;
      py <= load_y;
    end else if (!freeze && prev_btn == 4'd0 && btn != 4'd0) begin
      for (int d = 0; d < 4; d++) begin
        if (btn[d]) begin
          nx = int'(px) + dxf(d);
          ny = int'(py) + dyf(d);
          if (cell_open(maze, nx, ny)) begin
            px <= 3'(nx);
            py <= 3'(ny);
          end
        end
      end
    end
  end

  task automatic push_press(input int d, input int len);
    press_t p;
    p.vec = 4'b0001 << d;
    p.len = len;
    exp_q.push_back(p);
  endtask

  // Reference walk: wall-follow on the right from heading R until goal, dead end or step limit.
  task automatic model_run(input logic [63:0] m, input int sx, input int sy, input int tx, input int ty);
    int x, y, h, steps, d, c;
    bit fin, found;
    x = sx; y = sy; h = 2; steps = 0; d = 0;
    fin = 0; exp_done = 0; exp_fail = 0;
    if (x == tx && y == ty) begin exp_done = 1; fin = 1; end
    while (!fin) begin
      found = 0;
      for (int k = 0; k < 4; k++) begin
        c = (h + 3 + k) % 4;
        if (!found && cell_open(m, x + dxf(c), y + dyf(c))) begin found = 1; d = c; end
      end
      if (!found) begin
        exp_fail = 1; fin = 1;
      end else begin
        push_press(d, PC);
        x += dxf(d); y += dyf(d); h = d; steps++;
        if (x == tx && y == ty) begin exp_done = 1; fin = 1; end
        else if (steps == MS) begin exp_fail = 1; fin = 1; end
      end
    end
    exp_steps = steps;
  endtask

  // Monitor: pops one expected press per rising button and checks its width on release.
  logic [3:0] mon_prev = 4'd0;
  int cur_len = 0;
  int cur_exp = -1;

  always @(negedge clk) begin
    press_t e;
    if (btn != 4'd0 && mon_prev == 4'd0) begin
      if (exp_q.size() == 0) begin
        note_fail("unexpected_press", int'(btn));
        cur_exp = -1;
      end else begin
        e = exp_q.pop_front();
        chk("press_button", int'(btn), int'(e.vec));
        cur_exp = e.len;
      end
      cur_len = 1;
    end else if (btn != 4'd0) begin
      cur_len++;
    end else if (mon_prev != 4'd0 && cur_exp >= 0) begin
      chk("press_length", cur_len, cur_exp);
    end
    mon_prev = btn;
  end

  task automatic load_player(input int x, input int y);
    load_x = 3'(x); load_y = 3'(y); load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_level(input bit lvl, input string name);
    int n = 0;
    while (((btn != 4'd0) != lvl) && n < 200) begin @(negedge clk); n++; end
    if ((btn != 4'd0) != lvl) note_fail(name, n);
  endtask

  task automatic end_checks(input string name);
    int n = 0;
    @(negedge clk);
    while (busy && n < 1000) begin @(negedge clk); n++; end
    if (busy) note_fail({name, "_timeout"}, n);
    chk({name, "_done"}, int'(done), int'(exp_done));
    chk({name, "_fail"}, int'(fail), int'(exp_fail));
    chk({name, "_steps"}, int'(step_count), exp_steps);
    chk({name, "_presses_left"}, exp_q.size(), 0);
  endtask

  task automatic corridor_maze();
    maze = '1;
    maze[9] = 1'b0; maze[10] = 1'b0; maze[11] = 1'b0;
  endtask

  task automatic abort_second_press(input string name, input int steps_req);
    wait_level(1'b1, {name, "_wait_p1"});
    wait_level(1'b0, {name, "_wait_r1"});
    wait_level(1'b1, {name, "_wait_p2"});
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({name, "_btn_low"}, int'(btn), 0);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_steps"}, int'(step_count), steps_req);
    abort = 1'b0;
    @(negedge clk);
    chk({name, "_presses_left"}, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int sx, sy, tx, ty;
    rst = 1'b1; start = 1'b0; abort = 1'b0; maze = '1;
    repeat (2) @(negedge clk);
    chk("rst_btn", int'(btn), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_fail", int'(fail), 0);
    chk("rst_steps", int'(step_count), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Straight corridor to the goal at (3,1).
    corridor_maze();
    load_player(1, 1);
    gx = 3'd3; gy = 3'd1; goal_en = 1'b1;
    model_run(maze, 1, 1, 3, 1);
    pulse_start();
    end_checks("corridor");
    chk("corridor_done_const", int'(done), 1);
    chk("corridor_steps_const", int'(step_count), 2);

    // Right-hand preference: D beats R when heading R.
    maze = '1; maze[9] = 1'b0; maze[10] = 1'b0; maze[17] = 1'b0;
    load_player(1, 1);
    gx = 3'd1; gy = 3'd2; goal_en = 1'b1;
    model_run(maze, 1, 1, 1, 2);
    pulse_start();
    end_checks("prefer");

    // Dead end: fail quickly, never press.
    maze = '1; maze[9] = 1'b0;
    load_player(1, 1);
    goal_en = 1'b0;
    model_run(maze, 1, 1, -1, -1);
    pulse_start();
    begin
      int n = 0;
      while (!fail && n < 6) begin @(negedge clk); n++; end
    end
    chk("deadend_fail_in_6", int'(fail), 1);
    end_checks("deadend");

    // Abort on the second cycle of the second press.
    corridor_maze();
    load_player(1, 1);
    goal_en = 1'b0;
    push_press(2, PC);
    push_press(2, 2);
    pulse_start();
    abort_second_press("abort", 1);

    // Player that never moves.
    corridor_maze();
    load_player(1, 1);
    freeze = 1'b1;
`ifdef AUTOPLAY_MOVE_CHECK_EN
    push_press(2, PC);
    exp_done = 0; exp_fail = 1; exp_steps = 0;
    pulse_start();
    end_checks("stuck");
`else
    push_press(2, PC);
    push_press(2, 2);
    pulse_start();
    abort_second_press("stuck", 1);
`endif
    freeze = 1'b0;

    // Reset in the middle of the second press.
    corridor_maze();
    load_player(1, 1);
    goal_en = 1'b0;
    push_press(2, PC);
    push_press(2, 1);
    pulse_start();
    wait_level(1'b1, "rstmid_wait_p1");
    wait_level(1'b0, "rstmid_wait_r1");
    wait_level(1'b1, "rstmid_wait_p2");
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("rstmid_btn", int'(btn), 0);
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_steps", int'(step_count), 0);
    chk("rstmid_done", int'(done), 0);
    chk("rstmid_fail", int'(fail), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rstmid_presses_left", exp_q.size(), 0);

    // Random mazes against the reference walk.
    for (int r = 0; r < 8; r++) begin
      maze = {$urandom, $urandom} & {$urandom, $urandom};
      sx = $urandom_range(0, 7); sy = $urandom_range(0, 7);
      tx = $urandom_range(0, 7); ty = $urandom_range(0, 7);
      maze[6'(sy * 8 + sx)] = 1'b0;
      maze[6'(ty * 8 + tx)] = 1'b0;
      load_player(sx, sy);
      gx = 3'(tx); gy = 3'(ty); goal_en = 1'b1;
      model_run(maze, sx, sy, tx, ty);
      pulse_start();
      end_checks($sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
